// File: rtl/instr_loader_pkg.sv
// Shared pipeline definitions: loader FSM encodings and the default halt instruction.
package instr_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader.sv
// Streams received bytes into instruction memory until the halt word lands
// or the memory fills up.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int          INSTMEM_SIZE = 8,
   parameter int          MEM_SIZE     = 8,
   parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_start,
   input  logic                      i_clear,
   input  logic [MEM_SIZE-1:0]       i_rx_data,
   input  logic                      i_rx_valid,
   output logic                      o_instrmem_en,
   output logic                      o_write_en,
   output logic [MEM_SIZE-1:0]       o_write_data,
   output logic [INSTMEM_SIZE-1:0]   o_write_addr,
   output logic [INSTMEM_SIZE-2:0]   o_word_count,
   output logic                      o_done,
   output logic                      o_error
);

   state_e                    state_q, state_d;
   logic [INSTMEM_SIZE-1:0]   addr_q, addr_d;
   logic [31:0]               word_q, word_d;
   logic [INSTMEM_SIZE-2:0]   wc_q, wc_d;
   logic                      wen_q, wen_d;
   logic [MEM_SIZE-1:0]       wdata_q, wdata_d;
   logic [INSTMEM_SIZE-1:0]   waddr_q, waddr_d;
   logic                      fin_q, fin_d;
   logic                      fin_err_q, fin_err_d;
   logic [31:0]               word_next;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      word_d    = word_q;
      wc_d      = wc_q;
      wen_d     = 1'b0;
      wdata_d   = wdata_q;
      waddr_d   = waddr_q;
      fin_d     = fin_q;
      fin_err_d = fin_err_q;
      word_next = (word_q << MEM_SIZE) | 32'(i_rx_data);

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d   = ST_LOAD;
               addr_d    = '0;
               waddr_d   = '0;
               wc_d      = '0;
               fin_d     = 1'b0;
               fin_err_d = 1'b0;
            end
         end
         ST_LOAD: begin
            // fin_q marks the cycle carrying the final write; leave LOAD one cycle later
            if (fin_q) begin
               state_d = fin_err_q ? ST_ERROR : ST_DONE;
               fin_d   = 1'b0;
            end else if (i_rx_valid) begin
               wen_d   = 1'b1;
               wdata_d = i_rx_data;
               waddr_d = addr_q;
               addr_d  = addr_q + 1'b1;
               word_d  = word_next;
               if (&addr_q[1:0]) begin
                  wc_d = wc_q + 1'b1;
                  if (word_next == HALT_WORD) begin
                     fin_d     = 1'b1;
                     fin_err_d = 1'b0;
                  end else if (&addr_q) begin
                     fin_d     = 1'b1;
                     fin_err_d = 1'b1;
                  end
               end
            end
         end
         ST_DONE, ST_ERROR: begin
            if (i_clear) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         word_q    <= '0;
         wc_q      <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         waddr_q   <= '0;
         fin_q     <= 1'b0;
         fin_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         word_q    <= word_d;
         wc_q      <= wc_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         waddr_q   <= waddr_d;
         fin_q     <= fin_d;
         fin_err_q <= fin_err_d;
      end
   end

   assign o_instrmem_en = (state_q == ST_LOAD);
   assign o_write_en    = wen_q;
   assign o_write_data  = wdata_q;
   assign o_write_addr  = waddr_q;
   assign o_word_count  = wc_q;
   assign o_done        = (state_q == ST_DONE);
   assign o_error       = (state_q == ST_ERROR);

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter INSTMEM_SIZE, default 8, SHALL set the byte-address width of instruction memory (depth 2^INSTMEM_SIZE bytes).
REQ-002 Parameter MEM_SIZE, default 8, SHALL set the write-data width (one byte per write).
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF, SHALL set the instruction that terminates a program load.
REQ-004 i_clock  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle pulse; begins a program load.
REQ-007 i_clear  in  1  one-cycle pulse; returns the block from DONE/ERROR to IDLE.
REQ-008 i_rx_data  in  MEM_SIZE  received program byte.
REQ-009 i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
REQ-010 o_instrmem_en  out  1  instruction-memory enable; high in LOAD.
REQ-011 o_write_en  out  1  instruction-memory write strobe.
REQ-012 o_write_data  out  MEM_SIZE  byte to write.
REQ-013 o_write_addr  out  INSTMEM_SIZE  byte address of write.
REQ-014 o_word_count  out  INSTMEM_SIZE-1  count of complete 4-byte words written.
REQ-015 o_done  out  1  high in DONE.
REQ-016 o_error  out  1  high in ERROR (memory overflow).

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DONE, ERROR.
REQ-018 IDLE + i_start -> LOAD; byte address counter and o_word_count SHALL clear to 0 on this transition.
REQ-019 In LOAD, i_rx_valid in cycle N SHALL produce o_write_en=1 in cycle N+1 with o_write_data = byte and o_write_addr = current address; the address then increments by 1.
REQ-020 Back-to-back i_rx_valid (every cycle) SHALL be accepted without loss; o_write_en is a single-cycle pulse per byte.
REQ-021 Bytes SHALL be assembled into a 32-bit word shift register, first byte of each aligned word into bits [31:24], fourth into [7:0]; alignment is address[1:0].
REQ-022 On the byte completing an aligned word (address[1:0]==3), o_word_count SHALL increment by 1 in the same cycle as that byte's write.
REQ-023 If the completed word equals HALT_WORD, its fourth byte SHALL still be written, and the FSM SHALL enter DONE in the cycle after that write.
REQ-024 If the byte written at address 2^INSTMEM_SIZE-1 does not complete HALT_WORD, the FSM SHALL enter ERROR in the following cycle; the address SHALL NOT wrap to 0 for a further write.
REQ-025 i_rx_valid in IDLE, DONE, ERROR SHALL be ignored (no write).
REQ-026 i_start outside IDLE SHALL be ignored; i_clear in DONE or ERROR -> IDLE; i_clear in IDLE or LOAD SHALL be ignored.
REQ-027 i_start and i_clear in the same cycle SHALL be evaluated per current state only (at most one applies).
REQ-028 o_instrmem_en SHALL be high in LOAD and during the cycle carrying the final write pulse.
REQ-029 o_word_count, o_write_addr and o_write_data SHALL hold their last values in DONE and ERROR.

Reset
REQ-030 While i_reset_n=0 the FSM SHALL be IDLE; o_write_en, o_instrmem_en, o_done, o_error = 0; o_write_addr, o_write_data, o_word_count, word register = 0.
REQ-031 Reset asserted mid-LOAD SHALL abort immediately; any pending write pulse SHALL be suppressed.

Structure
REQ-032 FSM state encodings and the default HALT_WORD SHALL reside in a shared pipeline package/include file used also by the debug unit.
REQ-033 The block SHALL be a single module with no sub-modules; the address counter and word register are inline registers.

Verification
REQ-034 Reset, i_start, bytes 20,01,00,05 then FF,FF,FF,FF -> writes at addr 0..7, o_word_count=2, o_done=1 one cycle after addr 7 write.
REQ-035 Bytes FF,FF,FF at addr 0..2 then 00 -> no DONE; following FF,FF,FF,FF at addr 4..7 -> DONE, o_word_count=2.
REQ-036 INSTMEM_SIZE=4, 16 non-halt bytes -> writes at addr 0..15, o_error=1 in cycle after addr 15 write, 17th byte produces no write.
REQ-037 Eight consecutive-cycle i_rx_valid pulses -> eight consecutive o_write_en pulses, addr 0..7, data matching input order.
REQ-038 i_reset_n low after 3 bytes in LOAD -> all outputs 0; then i_start, byte 0xAA -> written at addr 0.
REQ-039 In DONE: i_rx_valid ignored, i_start ignored; i_clear -> IDLE; i_start -> LOAD with address 0.
